// File: rtl/match_pkg.sv
// Shared types and constants for the nine-round match controller.
package match_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] RES_DRAW = 2'b00;
  localparam logic [1:0] RES_WIN  = 2'b01;
  localparam logic [1:0] RES_LOSE = 2'b10;
  localparam logic [1:0] RES_BAD  = 2'b11;

  localparam logic [1:0] WIN_PLAYER = 2'b10;
  localparam logic [1:0] WIN_OPP    = 2'b01;
  localparam logic [1:0] WIN_TIE    = 2'b00;

  localparam int MAX_ROUNDS_DEFAULT = 9;

endpackage

// File: rtl/match_controller_if.sv
// Round-result handshake between the game datapath and the match controller.
interface match_controller_if;
  logic       result_valid;
  logic [1:0] result;
  logic       result_ready;

  modport master (output result_valid, output result, input  result_ready);
  modport slave  (input  result_valid, input  result, output result_ready);
endinterface

// File: rtl/match_finish_check.sv
// Combinational early-finish and winner evaluation on the registered counters.
module match_finish_check
  import match_pkg::*;
#(
  parameter int MAX_ROUNDS = MAX_ROUNDS_DEFAULT
) (
  input  logic [3:0] i_round,
  input  logic [3:0] i_win,
  input  logic [3:0] i_lose,
  output logic       o_fin_cond,
  output logic [1:0] o_winner_code
);

  // Sums are 5 bits wide so win/lose plus remaining rounds can never wrap.
  logic [4:0] w_remaining;
  logic [4:0] w_win;
  logic [4:0] w_lose;

  assign w_remaining = 5'(MAX_ROUNDS) - {1'b0, i_round};
  assign w_win       = {1'b0, i_win};
  assign w_lose      = {1'b0, i_lose};

  // Match is decided when one side can no longer be caught or all rounds are played.
  always_comb begin
    o_fin_cond    = (w_win > w_lose + w_remaining) ||
                    (w_lose > w_win + w_remaining) ||
                    (i_round == 4'(MAX_ROUNDS));
    o_winner_code = WIN_TIE;
    if (w_win > w_lose)      o_winner_code = WIN_PLAYER;
    else if (w_lose > w_win) o_winner_code = WIN_OPP;
  end

endmodule

// File: rtl/match_controller.sv
// Match FSM: accepts round results, keeps round/win/lose counters, enforces the
// per-round timeout and holds the final outcome until the next start.
module match_controller
  import match_pkg::*;
#(
  parameter int MAX_ROUNDS     = MAX_ROUNDS_DEFAULT,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  match_controller_if.slave        res_if,
  output logic [3:0]               round,
  output logic [3:0]               win,
  output logic [3:0]               lose,
  output logic                     fin,
  output logic [1:0]               winner,
  output logic                     timeout,
  output logic                     err
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_PLAY  = ST_PLAY;
  localparam logic [1:0] S_CHECK = ST_CHECK;
  localparam logic [1:0] S_DONE  = ST_DONE;

  localparam int            TW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    r_state;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_round;
  logic [3:0]    r_win;
  logic [3:0]    r_lose;
  logic [1:0]    r_winner;
  logic          r_timeout;
  logic          r_err;

  logic       w_play;
  logic       w_start;
  logic       w_hs;
  logic       w_bad;
  logic       w_tmo;
  logic       w_score;
  logic       w_add_win;
  logic       w_add_lose;
  logic       w_fin_cond;
  logic [1:0] w_winner_code;

  assign w_play     = (r_state == S_PLAY);
  assign w_start    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_hs       = w_play && res_if.result_valid;
  assign w_bad      = w_hs && (res_if.result == RES_BAD);
  // A handshake in the final timer cycle wins over the timeout.
  assign w_tmo      = w_play && !res_if.result_valid && (r_timer == TMAX);
  assign w_score    = (w_hs && !w_bad) || w_tmo;
  assign w_add_win  = w_hs && (res_if.result == RES_WIN);
  assign w_add_lose = (w_hs && (res_if.result == RES_LOSE)) || w_tmo;

  match_finish_check #(.MAX_ROUNDS(MAX_ROUNDS)) u_finish (
    .i_round       (r_round),
    .i_win         (r_win),
    .i_lose        (r_lose),
    .o_fin_cond    (w_fin_cond),
    .o_winner_code (w_winner_code)
  );

  // State transitions and the per-round PLAY timer (restarted on entry and on an invalid code).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_timer <= '0;
    end else begin
      r_timer <= (w_play && !w_hs && !w_tmo) ? r_timer + TW'(1) : '0;
      case (r_state)
        S_IDLE, S_DONE: if (w_start) r_state <= S_PLAY;
        S_PLAY:         if (w_score) r_state <= S_CHECK;
        S_CHECK:        r_state <= w_fin_cond ? S_DONE : S_PLAY;
        default:        r_state <= S_IDLE;
      endcase
    end
  end

  // Round/win/lose counters and the latched winner, cleared on every match start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_round  <= '0;
      r_win    <= '0;
      r_lose   <= '0;
      r_winner <= WIN_TIE;
    end else if (w_start) begin
      r_round  <= '0;
      r_win    <= '0;
      r_lose   <= '0;
      r_winner <= WIN_TIE;
    end else begin
      if (w_score)    r_round <= r_round + 4'd1;
      if (w_add_win)  r_win   <= r_win + 4'd1;
      if (w_add_lose) r_lose  <= r_lose + 4'd1;
      if ((r_state == S_CHECK) && w_fin_cond) r_winner <= w_winner_code;
    end
  end

  // Single-cycle timeout and invalid-code pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timeout <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_timeout <= w_tmo;
      r_err     <= w_bad;
    end
  end

  assign res_if.result_ready = w_play;
  assign round   = r_round;
  assign win     = r_win;
  assign lose    = r_lose;
  assign fin     = (r_state == S_DONE);
  assign winner  = fin ? r_winner : WIN_TIE;
  assign timeout = r_timeout;
  assign err     = r_err;

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller: directed scenarios plus randomized
// matches scored by a round-level reference model.
module tb_match_controller;

  localparam int MAXR = 9;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [3:0] round, win, lose;
  logic       fin, timeout, err;
  logic [1:0] winner;

  int tests = 0;
  int fails = 0;

  match_controller_if bus ();

  match_controller #(.MAX_ROUNDS(MAXR), .TIMEOUT_CYCLES(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .res_if  (bus),
    .round   (round),
    .win     (win),
    .lose    (lose),
    .fin     (fin),
    .winner  (winner),
    .timeout (timeout),
    .err     (err)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [1:0] code);
    bus.result_valid = 1'b1;
    bus.result       = code;
    tick();
    bus.result_valid = 1'b0;
  endtask

  function automatic bit model_fin(input int r, input int w, input int l);
    int rem;
    rem = MAXR - r;
    return (w > l + rem) || (l > w + rem) || (r == MAXR);
  endfunction

  function automatic logic [1:0] model_winner(input int w, input int l);
    if (w > l) return 2'b10;
    if (l > w) return 2'b01;
    return 2'b00;
  endfunction

  task automatic test_reset();
    #2;
    tests++;
    if ({round, win, lose, fin, winner, timeout, err, bus.result_ready} !== 18'd0) begin
      fails++;
      $display("FAIL reset_initial: outputs=%h expected 0",
               {round, win, lose, fin, winner, timeout, err, bus.result_ready});
    end
    tick();
    reset_n = 1'b1;
    tick();
    do_start();
    send(2'b01);
    tick();
    tests++;
    if (bus.result_ready !== 1'b1 || round !== 4'd1) begin
      fails++;
      $display("FAIL reset_setup: ready=%b round=%0d expected 1/1", bus.result_ready, round);
    end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if ({round, win, lose, fin, winner, timeout, err, bus.result_ready} !== 18'd0) begin
      fails++;
      $display("FAIL reset_async: outputs=%h expected 0",
               {round, win, lose, fin, winner, timeout, err, bus.result_ready});
    end
    tick();
    reset_n = 1'b1;
    bus.result_valid = 1'b1;
    bus.result = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (bus.result_ready !== 1'b0 || round !== 4'd0) begin
        fails++;
        $display("FAIL reset_idle_hold: ready=%b round=%0d expected 0/0", bus.result_ready, round);
      end
    end
    bus.result_valid = 1'b0;
    do_start();
    tests++;
    if (bus.result_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_start_ready: ready=%b expected 1", bus.result_ready);
    end
  endtask

  task automatic test_early_win();
    for (int i = 1; i <= 5; i++) begin
      send(2'b01);
      tests++;
      if ({round, win, lose, bus.result_ready} !== {4'(i), 4'(i), 4'd0, 1'b0}) begin
        fails++;
        $display("FAIL early_counts_%0d: r/w/l=%0d/%0d/%0d ready=%b expected %0d/%0d/0 ready=0",
                 i, round, win, lose, bus.result_ready, i, i);
      end
      tick();
      if (i < 5) begin
        tests++;
        if (fin !== 1'b0 || bus.result_ready !== 1'b1) begin
          fails++;
          $display("FAIL early_not_fin_%0d: fin=%b ready=%b expected 0/1", i, fin, bus.result_ready);
        end
      end else begin
        tests++;
        if ({fin, winner, round, win, lose} !== {1'b1, 2'b10, 4'd5, 4'd5, 4'd0}) begin
          fails++;
          $display("FAIL early_fin: fin=%b winner=%b r/w/l=%0d/%0d/%0d expected 1/10 5/5/0",
                   fin, winner, round, win, lose);
        end
      end
    end
  endtask

  task automatic test_tie_match();
    logic [1:0] seq [9];
    seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    do_start();
    for (int i = 0; i < 9; i++) begin
      send(seq[i]);
      tick();
      if (i == 7) begin
        tests++;
        if (fin !== 1'b0 || bus.result_ready !== 1'b1) begin
          fails++;
          $display("FAIL tie_round8: fin=%b ready=%b expected 0/1", fin, bus.result_ready);
        end
      end
    end
    tests++;
    if ({fin, winner, round, win, lose} !== {1'b1, 2'b00, 4'd9, 4'd4, 4'd4}) begin
      fails++;
      $display("FAIL tie_fin: fin=%b winner=%b r/w/l=%0d/%0d/%0d expected 1/00 9/4/4",
               fin, winner, round, win, lose);
    end
  endtask

  task automatic test_timeout();
    do_start();
    for (int k = 1; k <= 15; k++) begin
      tick();
      tests++;
      if (timeout !== 1'b0) begin
        fails++;
        $display("FAIL timeout_early_%0d: timeout=%b expected 0", k, timeout);
      end
    end
    tick();
    tests++;
    if ({timeout, round, lose, win} !== {1'b1, 4'd1, 4'd1, 4'd0}) begin
      fails++;
      $display("FAIL timeout_pulse: timeout=%b r/l/w=%0d/%0d/%0d expected 1 1/1/0",
               timeout, round, lose, win);
    end
    tick();
    tests++;
    if (timeout !== 1'b0 || bus.result_ready !== 1'b1 || fin !== 1'b0) begin
      fails++;
      $display("FAIL timeout_back_to_play: timeout=%b ready=%b fin=%b expected 0/1/0",
               timeout, bus.result_ready, fin);
    end
    for (int k = 1; k <= 15; k++) tick();
    send(2'b01);
    tests++;
    if ({timeout, round, win, lose} !== {1'b0, 4'd2, 4'd1, 4'd1}) begin
      fails++;
      $display("FAIL timeout_last_cycle_hs: timeout=%b r/w/l=%0d/%0d/%0d expected 0 2/1/1",
               timeout, round, win, lose);
    end
    tick();
  endtask

  task automatic test_invalid();
    send(2'b11);
    tests++;
    if ({err, round, win, lose, bus.result_ready} !== {1'b1, 4'd2, 4'd1, 4'd1, 1'b1}) begin
      fails++;
      $display("FAIL invalid_err: err=%b r/w/l=%0d/%0d/%0d ready=%b expected 1 2/1/1 ready=1",
               err, round, win, lose, bus.result_ready);
    end
    tick();
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL invalid_pulse_width: err=%b expected 0", err);
    end
    for (int k = 2; k <= 15; k++) begin
      tick();
      tests++;
      if (timeout !== 1'b0) begin
        fails++;
        $display("FAIL invalid_timer_restart_%0d: timeout=%b expected 0", k, timeout);
      end
    end
    tick();
    tests++;
    if (timeout !== 1'b1 || lose !== 4'd2) begin
      fails++;
      $display("FAIL invalid_then_timeout: timeout=%b lose=%0d expected 1/2", timeout, lose);
    end
    tick();
  endtask

  task automatic test_restart();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    do_start();
    for (int i = 0; i < 5; i++) begin
      send(2'b10);
      tick();
    end
    tests++;
    if ({fin, winner, round, lose} !== {1'b1, 2'b01, 4'd5, 4'd5}) begin
      fails++;
      $display("FAIL restart_opp_win: fin=%b winner=%b r/l=%0d/%0d expected 1/01 5/5",
               fin, winner, round, lose);
    end
    bus.result_valid = 1'b1;
    bus.result = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if ({fin, bus.result_ready, round, win, lose} !== {1'b1, 1'b0, 4'd5, 4'd0, 4'd5}) begin
        fails++;
        $display("FAIL restart_done_hold: fin=%b ready=%b r/w/l=%0d/%0d/%0d expected 1/0 5/0/5",
                 fin, bus.result_ready, round, win, lose);
      end
    end
    bus.result_valid = 1'b0;
    do_start();
    tests++;
    if ({fin, winner, bus.result_ready, round, win, lose} !== {1'b0, 2'b00, 1'b1, 12'd0}) begin
      fails++;
      $display("FAIL restart_clear: fin=%b winner=%b ready=%b r/w/l=%0d/%0d/%0d expected 0/00/1 0/0/0",
               fin, winner, bus.result_ready, round, win, lose);
    end
  endtask

  task automatic test_random();
    int  mr, mw, ml, g, code, guard;
    bit  done, tmo, ef;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int m = 0; m < 8; m++) begin
      do_start();
      mr = 0; mw = 0; ml = 0; done = 0; guard = 0;
      while (!done && guard < 60) begin
        guard++;
        g    = $urandom_range(0, 17);
        code = $urandom_range(0, 3);
        tmo  = 0;
        for (int k = 1; k <= g && !tmo; k++) begin
          tick();
          tests++;
          if (timeout !== (k == 16)) begin
            fails++;
            $display("FAIL rand_timeout m%0d idle%0d: timeout=%b expected %b", m, k, timeout, k == 16);
          end
          if (k == 16) tmo = 1;
        end
        if (!tmo) begin
          send(code[1:0]);
          if (code == 3) begin
            tests++;
            if ({err, bus.result_ready, round, win, lose} !== {1'b1, 1'b1, 4'(mr), 4'(mw), 4'(ml)}) begin
              fails++;
              $display("FAIL rand_invalid m%0d: err=%b ready=%b r/w/l=%0d/%0d/%0d expected 1/1 %0d/%0d/%0d",
                       m, err, bus.result_ready, round, win, lose, mr, mw, ml);
            end
            continue;
          end
        end
        mr++;
        if (tmo || code == 2) ml++;
        else if (code == 1) mw++;
        tests++;
        if ({round, win, lose, err} !== {4'(mr), 4'(mw), 4'(ml), 1'b0}) begin
          fails++;
          $display("FAIL rand_counts m%0d: r/w/l=%0d/%0d/%0d err=%b expected %0d/%0d/%0d err=0",
                   m, round, win, lose, err, mr, mw, ml);
        end
        tick();
        ef = model_fin(mr, mw, ml);
        tests++;
        if ({fin, winner, bus.result_ready} !== {ef, ef ? model_winner(mw, ml) : 2'b00, !ef}) begin
          fails++;
          $display("FAIL rand_check m%0d round%0d: fin=%b winner=%b ready=%b expected %b/%b/%b",
                   m, mr, fin, winner, bus.result_ready, ef, ef ? model_winner(mw, ml) : 2'b00, !ef);
        end
        done = ef;
      end
      if (!done) begin
        tests++;
        fails++;
        $display("FAIL rand_match_end m%0d: match not finished within round budget", m);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
      end
    end
  endtask

  initial begin
    reset_n          = 1'b0;
    start            = 1'b0;
    bus.result_valid = 1'b0;
    bus.result       = 2'b00;
    test_reset();
    test_early_win();
    test_tie_match();
    test_timeout();
    test_invalid();
    test_restart();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
